// File: rtl/gtp_drp_arbiter.sv
// Purpose : round-robin share of one GTP DRP port between two requesters (read, write, masked RMW).
// Latency : ready 1 cycle after grant edge; done 3 cycles (read/full write) or 5 cycles (RMW) with 1-cycle drp_rdy.
// Backpr. : requesters hold reqN_valid until reqN_ready; a missing drp_rdy aborts after TIMEOUT_CYCLES.
// Ports   : clock/reset; req0_*/req1_* request + response; drp_* to transceiver DRP pins; busy = not IDLE.
module gtp_drp_arbiter #(
   parameter int ADDR_WIDTH     = 9,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic [DATA_WIDTH-1:0] req0_mask,
   output logic                  req0_ready,
   output logic                  req0_done,
   output logic [DATA_WIDTH-1:0] req0_rdata,
   output logic                  req0_timeout,
   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic [DATA_WIDTH-1:0] req1_mask,
   output logic                  req1_ready,
   output logic                  req1_done,
   output logic [DATA_WIDTH-1:0] req1_rdata,
   output logic                  req1_timeout,
   output logic                  drp_en,
   output logic                  drp_we,
   output logic [ADDR_WIDTH-1:0] drp_addr,
   output logic [DATA_WIDTH-1:0] drp_di,
   input  logic [DATA_WIDTH-1:0] drp_do,
   input  logic                  drp_rdy,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   // Counter compares against the last wait cycle so the abort lands on the TIMEOUT_CYCLES-th cycle.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                state;
   logic                  gnt_id;
   logic                  last_id;
   logic                  op_rmw;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [DATA_WIDTH-1:0] old_q;
   logic [7:0]            tmo_cnt;

   logic                  sel_id;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [DATA_WIDTH-1:0] sel_mask;
   logic [DATA_WIDTH-1:0] rmw_data;
   logic                  tmo_hit;
   logic                  fin;
   logic                  fin_tmo;
   logic [DATA_WIDTH-1:0] fin_rdata;

   // Contention goes to whoever was not served last; a lone request always wins.
   always_comb begin
      if (req0_valid && req1_valid) sel_id = ~last_id;
      else                          sel_id = req1_valid;
      sel_write = sel_id ? req1_write : req0_write;
      sel_addr  = sel_id ? req1_addr  : req0_addr;
      sel_wdata = sel_id ? req1_wdata : req0_wdata;
      sel_mask  = sel_id ? req1_mask  : req0_mask;
   end

   assign rmw_data = (drp_do & ~mask_q) | (wdata_q & mask_q);
   assign tmo_hit  = (tmo_cnt == TMO_LAST);
   assign busy     = (state != IDLE);

   // Completion of the current operation; rdata is zero on abort and for full writes.
   always_comb begin
      fin       = 1'b0;
      fin_tmo   = 1'b0;
      fin_rdata = '0;
      case (state)
         RD_WAIT: begin
            if (drp_rdy) begin
               fin       = ~op_rmw;
               fin_rdata = drp_do;
            end else if (tmo_hit) begin
               fin     = 1'b1;
               fin_tmo = 1'b1;
            end
         end
         WR_WAIT: begin
            if (drp_rdy) begin
               fin       = 1'b1;
               fin_rdata = op_rmw ? old_q : '0;
            end else if (tmo_hit) begin
               fin     = 1'b1;
               fin_tmo = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         gnt_id       <= 1'b0;
         last_id      <= 1'b1;   // req0 wins the first contention
         op_rmw       <= 1'b0;
         wdata_q      <= '0;
         mask_q       <= '0;
         old_q        <= '0;
         tmo_cnt      <= '0;
         req0_ready   <= 1'b0;
         req0_done    <= 1'b0;
         req0_rdata   <= '0;
         req0_timeout <= 1'b0;
         req1_ready   <= 1'b0;
         req1_done    <= 1'b0;
         req1_rdata   <= '0;
         req1_timeout <= 1'b0;
         drp_en       <= 1'b0;
         drp_we       <= 1'b0;
         drp_addr     <= '0;
         drp_di       <= '0;
      end else begin
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         drp_en     <= 1'b0;
         drp_we     <= 1'b0;

         case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  gnt_id     <= sel_id;
                  wdata_q    <= sel_wdata;
                  mask_q     <= sel_mask;
                  tmo_cnt    <= '0;
                  req0_ready <= ~sel_id;
                  req1_ready <= sel_id;
                  drp_en     <= 1'b1;
                  drp_addr   <= sel_addr;
                  // Only an all-ones mask skips the read; any partial (even empty) mask is RMW.
                  if (sel_write && (&sel_mask)) begin
                     drp_we <= 1'b1;
                     drp_di <= sel_wdata;
                     op_rmw <= 1'b0;
                     state  <= WR_WAIT;
                  end else begin
                     op_rmw <= sel_write;
                     state  <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (drp_rdy) begin
                  old_q <= drp_do;
                  if (op_rmw) begin
                     // Write-back reuses drp_addr, which still holds the read address.
                     drp_en  <= 1'b1;
                     drp_we  <= 1'b1;
                     drp_di  <= rmw_data;
                     tmo_cnt <= '0;
                     state   <= WR_WAIT;
                  end else begin
                     state <= DONE;
                  end
               end else if (tmo_hit) begin
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            WR_WAIT: begin
               if (drp_rdy || tmo_hit) state <= DONE;
               else                    tmo_cnt <= tmo_cnt + 8'd1;
            end
            DONE: begin
               last_id <= gnt_id;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (fin) begin
            if (gnt_id) begin
               req1_done    <= 1'b1;
               req1_rdata   <= fin_rdata;
               req1_timeout <= fin_tmo;
            end else begin
               req0_done    <= 1'b1;
               req0_rdata   <= fin_rdata;
               req0_timeout <= fin_tmo;
            end
         end
      end
   end

endmodule

// File: doc/gtp_drp_arbiter.md
Name: gtp_drp_arbiter

Overview:
- Shares the single DRP port of a GTP channel between two requesters, e.g. a runtime configuration engine and a debug/eye-scan engine.
- Performs plain reads, full writes, and masked read-modify-write (RMW) cycles.
- Arbitrates round-robin and aborts any DRP access whose ready strobe never arrives.
- Sits on the DRP clock domain (125 MHz DRP clock), between the requesters and the transceiver wrapper's DRP pins.

Parameters:
- ADDR_WIDTH, 9, DRP address width.
- DATA_WIDTH, 16, DRP data width.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for drp_rdy per DRP access (range 2..255).

Ports:
- clock  in  1  DRP clock; all logic on rising edge.
- reset  in  1  Asynchronous, active-high; clears all state and outputs.
- reqN_valid  in  1  (N=0,1) request pending; held until reqN_ready is seen.
- reqN_write  in  1  1 = write/RMW, 0 = read.
- reqN_addr  in  ADDR_WIDTH  DRP address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_mask  in  DATA_WIDTH  bits to replace; all-ones = plain write.
- reqN_ready  out  1  one-cycle pulse: request accepted; fields captured.
- reqN_done  out  1  one-cycle pulse: operation finished.
- reqN_rdata  out  DATA_WIDTH  read data (reads) or pre-write value (RMW); valid with done.
- reqN_timeout  out  1  qualifies done: operation aborted.
- drp_en  out  1  DRP enable, one-cycle pulse per access.
- drp_we  out  1  DRP write enable, asserted with drp_en for writes.
- drp_addr  out  ADDR_WIDTH  DRP address.
- drp_di  out  DATA_WIDTH  DRP write data.
- drp_do  in  DATA_WIDTH  DRP read data, valid with drp_rdy.
- drp_rdy  in  1  DRP access complete.
- busy  out  1  high whenever not IDLE.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; round-robin pointer favours req0; timeout counter 0.
  - Reset mid-operation discards the in-flight access; no done is issued.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- Grant (IDLE):
  - On an edge sampling any valid, select the requester:
    - Only one valid: that one wins.
    - Both valid: the one not granted last wins.
  - Capture addr/wdata/mask/write and the grant id.
  - Registered outputs for one cycle after that edge: reqN_ready=1, drp_en=1, drp_addr=addr.
  - Write with mask all-ones: drp_we=1, drp_di=wdata; go to WR_WAIT.
  - Otherwise (read, or write with partial mask): drp_we=0; go to RD_WAIT.
  - Requester drops valid on the edge where it sees ready. The arbiter cannot re-grant sooner than 3 cycles later.
- Mask all-zeros on a write: still performs the RMW; writes back the old value unchanged.
- RD_WAIT:
  - On an edge with drp_rdy=1, latch old=drp_do.
  - Plain read: go to DONE with rdata=old.
  - RMW: new = (old & ~mask) | (wdata & mask). Next cycle drive drp_en=1, drp_we=1, drp_di=new at the same address; go to WR_WAIT; rdata=old.
- WR_WAIT: on an edge with drp_rdy=1, go to DONE.
- Timeout:
  - Counter resets on entry to each wait state and increments every cycle without drp_rdy.
  - On reaching TIMEOUT_CYCLES, go to DONE with timeout=1 and rdata=0.
  - An RMW that times out in its read phase never issues the write.
- DONE:
  - One cycle: reqN_done=1 for the granted id, with rdata/timeout driven.
  - Update the round-robin pointer; return to IDLE.
  - rdata/timeout hold until the next done for that requester.
- drp_rdy sampled in IDLE or DONE (late or spurious) is ignored.
- drp_en never pulses while an access is outstanding.
- Latency, with drp_rdy arriving on the first cycle after drp_en:
  - Read or full write: ready at T+1, done at T+3.
  - RMW: done at T+5.

Test Plan:
- req0 read addr 0x011, model returns 0x5A5A after 1 cycle -> one drp_en with we=0; req0_done at T+3; rdata=0x5A5A; timeout=0.
- req1 write addr 0x060, wdata 0xBEEF, mask 0xFFFF -> single drp_en with we=1, di=0xBEEF; no read issued; req1_done.
- req0 RMW addr 0x005, old 0x1234, wdata 0xABCD, mask 0x00F0 -> read then write di=0x12C4; rdata=0x1234; done at T+5.
- Both valid continuously for 4 requests -> grant order req0, req1, req0, req1; each done pulse routed to the correct requester.
- Model never asserts drp_rdy, TIMEOUT_CYCLES=8 -> done with timeout=1 and rdata=0 after 8 wait cycles. A late drp_rdy afterwards is ignored; the next request proceeds normally.
- Assert reset during RMW WR_WAIT -> all outputs 0 immediately; no done. After release, req1 and req0 simultaneously valid -> req0 granted first.
